ipsum_fifo_ctrl: RTL and testbench

Token-engine controller for the read direction of the GLB path. It fetches input partial sums (ipsum) from the GLB through the shared arbiter and pushes the returned words into the ipsum FIFO. It also pops the FIFO toward the PE array on L2 command. It is the counterpart of the opsum FIFO controller: that block drains a FIFO into GLB writes, and this block fills a FIFO from GLB reads. Credit accounting guarantees the FIFO is never overrun, including by reads still in flight.

---
 rtl/ipsum_fifo_ctrl_pkg.sv | 24 ++
 rtl/ipsum_fifo_ctrl_if.sv | 42 ++++
 rtl/ipsum_fifo_ctrl_glb_rd_delay_line.sv | 36 +++
 rtl/ipsum_fifo_ctrl.sv | 75 +++++++
 tb/tb_ipsum_fifo_ctrl.sv | 327 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ipsum_fifo_ctrl_pkg.sv
// Shared token-engine constants for the ipsum (read) and opsum (write) FIFO
// controllers, plus the byte-mask helper used on GLB return data.
package ipsum_fifo_ctrl_pkg;

  localparam int TE_ADDR_W      = 32;
  localparam int TE_DATA_W      = 32;
  localparam int TE_WEB_W       = TE_DATA_W / 8;
  localparam int TE_IPSUM_DEPTH = 8;
  localparam int TE_OPSUM_DEPTH = 8;
  localparam int TE_RD_LAT      = 2;
  localparam int TE_WR_LAT      = 1;

  typedef logic [TE_WEB_W-1:0]  web_t;
  typedef logic [TE_DATA_W-1:0] data_t;
  typedef logic [TE_ADDR_W-1:0] addr_t;

  // Bytes whose web bit is clear are forced to zero.
  function automatic data_t mask_bytes(input data_t d, input web_t web);
    data_t m;
    for (int b = 0; b < TE_WEB_W; b++) m[b*8 +: 8] = web[b] ? d[b*8 +: 8] : 8'h00;
    return m;
  endfunction

endpackage

// File: rtl/ipsum_fifo_ctrl_if.sv
// L2 command, FIFO and GLB-arbiter signals of the ipsum FIFO controller.
// master = controller side, slave = environment (L2, FIFO, arbiter, GLB).
interface ipsum_fifo_ctrl_if;
  import ipsum_fifo_ctrl_pkg::*;

  logic  ipsum_fifo_reset_i;
  logic  ipsum_need_push_i;
  logic  ipsum_need_pop_i;
  web_t  ipsum_push_web_i;
  logic  ipsum_permit_push_i;
  logic  ipsum_fifo_empty_i;
  logic  ipsum_fifo_full_i;
  addr_t ipsum_glb_base_addr_i;
  data_t ipsum_glb_rdata_i;

  logic  ipsum_fifo_reset_o;
  logic  ipsum_fifo_push_en_o;
  data_t ipsum_fifo_push_data_o;
  logic  ipsum_fifo_pop_en_o;
  logic  ipsum_glb_read_req_o;
  addr_t ipsum_glb_read_addr_o;
  logic  ipsum_overflow_o;

  modport master (
    input  ipsum_fifo_reset_i, ipsum_need_push_i, ipsum_need_pop_i, ipsum_push_web_i,
           ipsum_permit_push_i, ipsum_fifo_empty_i, ipsum_fifo_full_i,
           ipsum_glb_base_addr_i, ipsum_glb_rdata_i,
    output ipsum_fifo_reset_o, ipsum_fifo_push_en_o, ipsum_fifo_push_data_o,
           ipsum_fifo_pop_en_o, ipsum_glb_read_req_o, ipsum_glb_read_addr_o,
           ipsum_overflow_o
  );

  modport slave (
    output ipsum_fifo_reset_i, ipsum_need_push_i, ipsum_need_pop_i, ipsum_push_web_i,
           ipsum_permit_push_i, ipsum_fifo_empty_i, ipsum_fifo_full_i,
           ipsum_glb_base_addr_i, ipsum_glb_rdata_i,
    input  ipsum_fifo_reset_o, ipsum_fifo_push_en_o, ipsum_fifo_push_data_o,
           ipsum_fifo_pop_en_o, ipsum_glb_read_req_o, ipsum_glb_read_addr_o,
           ipsum_overflow_o
  );

endinterface

// File: rtl/ipsum_fifo_ctrl_glb_rd_delay_line.sv
// STAGES-deep valid + byte-enable shift register tracking GLB reads in flight.
// clr drops every in-flight entry.
module glb_rd_delay_line
  import ipsum_fifo_ctrl_pkg::*;
#(
  parameter int STAGES = TE_RD_LAT
) (
  input  logic clk,
  input  logic clr,
  input  logic in_vld,
  input  web_t in_web,
  output logic out_vld,
  output web_t out_web
);

  logic [STAGES:1]               vld_pipe;
  logic [STAGES:1][TE_WEB_W-1:0] web_pipe;

  always_ff @(posedge clk) begin
    if (clr) begin
      vld_pipe <= '0;
      web_pipe <= '0;
    end else begin
      for (int s = STAGES; s > 1; s--) begin
        vld_pipe[s] <= vld_pipe[s-1];
        web_pipe[s] <= web_pipe[s-1];
      end
      vld_pipe[1] <= in_vld;
      web_pipe[1] <= in_web;
    end
  end

  assign out_vld = vld_pipe[STAGES];
  assign out_web = web_pipe[STAGES];

endmodule

// File: rtl/ipsum_fifo_ctrl.sv
// Fills the ipsum FIFO from GLB reads and pops it toward the PE array.
// Credits count free FIFO slots minus reads in flight, so the FIFO cannot overrun.
module ipsum_fifo_ctrl
  import ipsum_fifo_ctrl_pkg::*;
#(
  parameter int DEPTH     = TE_IPSUM_DEPTH,
  parameter int RD_LAT    = TE_RD_LAT,
  parameter int REQ_CNT_W = 4
) (
  input logic           clk,
  input logic           rst,
  ipsum_fifo_ctrl_if.master bus
);

  localparam int CRED_W = $clog2(DEPTH + 1);

  logic [REQ_CNT_W-1:0] req_cnt;
  logic [CRED_W-1:0]    credit;
  logic [15:0]          read_ptr;
  logic                 overflow;
  logic                 flush, read_req, issue, pop_en;
  logic                 tail_vld;
  web_t                 tail_web;

  assign flush    = rst | bus.ipsum_fifo_reset_i;
  assign read_req = (req_cnt != '0) && (credit != '0);
  assign issue    = read_req && bus.ipsum_permit_push_i;
  assign pop_en   = bus.ipsum_need_pop_i && !bus.ipsum_fifo_empty_i;

  // Coincident push request and issue cancel; requests beyond saturation are lost.
  always_ff @(posedge clk) begin
    if (flush) begin
      req_cnt <= '0;
    end else if (bus.ipsum_need_push_i && !issue) begin
      if (req_cnt != '1) req_cnt <= req_cnt + 1'b1;
    end else if (issue && !bus.ipsum_need_push_i) begin
      req_cnt <= req_cnt - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (flush)                 credit <= CRED_W'(DEPTH);
    else if (issue && !pop_en) credit <= credit - 1'b1;
    else if (pop_en && !issue) credit <= credit + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (flush)      read_ptr <= '0;
    else if (issue) read_ptr <= read_ptr + 16'd1;
  end

  glb_rd_delay_line #(.STAGES(RD_LAT)) u_rd_dly (
    .clk     (clk),
    .clr     (flush),
    .in_vld  (issue),
    .in_web  (bus.ipsum_push_web_i),
    .out_vld (tail_vld),
    .out_web (tail_web)
  );

  // Sticky: only a reset or FIFO flush clears it.
  always_ff @(posedge clk) begin
    if (flush)                                  overflow <= 1'b0;
    else if (tail_vld && bus.ipsum_fifo_full_i) overflow <= 1'b1;
  end

  assign bus.ipsum_fifo_reset_o     = bus.ipsum_fifo_reset_i;
  assign bus.ipsum_fifo_pop_en_o    = pop_en;
  assign bus.ipsum_glb_read_req_o   = read_req;
  assign bus.ipsum_glb_read_addr_o  = bus.ipsum_glb_base_addr_i + {16'h0000, read_ptr};
  assign bus.ipsum_fifo_push_en_o   = tail_vld;
  assign bus.ipsum_fifo_push_data_o = tail_vld ? mask_bytes(bus.ipsum_glb_rdata_i, tail_web) : '0;
  assign bus.ipsum_overflow_o       = overflow;

endmodule

// File: tb/tb_ipsum_fifo_ctrl.sv
// Directed bench for ipsum_fifo_ctrl: a GLB model answers reads, a monitor
// checks every issue and FIFO push against scoreboard queues.
module tb_ipsum_fifo_ctrl;
  localparam int DEPTH  = 8;
  localparam int RD_LAT = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ipsum_fifo_ctrl_if bus ();

  ipsum_fifo_ctrl #(.DEPTH(DEPTH), .RD_LAT(RD_LAT), .REQ_CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int issues      = 0;
  int exp_ptr     = 0;
  logic [31:0] cur_base;
  logic [3:0]  cur_web;
  logic [31:0] exp_addr_q[$];
  logic [31:0] exp_data_q[$];
  logic        hv[RD_LAT];
  logic [31:0] ha[RD_LAT];

  function automatic logic [31:0] glb_word(input logic [31:0] a);
    if (a == 32'h0000_0100) return 32'hAABB_CCDD;
    return a ^ 32'h5A3C_9600;
  endfunction

  function automatic logic [31:0] apply_web(input logic [31:0] d, input logic [3:0] w);
    return d & {{8{w[3]}}, {8{w[2]}}, {8{w[1]}}, {8{w[0]}}};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  task automatic expect_fetch();
    logic [31:0] a;
    a = cur_base + 32'(exp_ptr);
    exp_addr_q.push_back(a);
    exp_data_q.push_back(apply_web(glb_word(a), cur_web));
    exp_ptr++;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_flush();
    bus.ipsum_fifo_reset_i  = 1'b1;
    bus.ipsum_need_push_i   = 1'b0;
    bus.ipsum_permit_push_i = 1'b0;
    sample();
    check_bit("fifo_reset_o", bus.ipsum_fifo_reset_o, 1'b1);
    next();
    bus.ipsum_fifo_reset_i = 1'b0;
    exp_ptr = 0;
  endtask

  task automatic set_base(input logic [31:0] b, input logic [3:0] w);
    cur_base = b;
    cur_web  = w;
    bus.ipsum_glb_base_addr_i = b;
    bus.ipsum_push_web_i      = w;
  endtask

  // Monitor first, then the GLB model advances and drives next cycle's rdata.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!rst) begin
      if (bus.ipsum_fifo_push_en_o) begin
        if (exp_data_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_push: got data %h expected no push at %0t",
                   bus.ipsum_fifo_push_data_o, $time);
        end else begin
          e = exp_data_q.pop_front();
          check("push_data", bus.ipsum_fifo_push_data_o, e);
        end
      end
      if (bus.ipsum_glb_read_req_o && bus.ipsum_permit_push_i) begin
        issues++;
        if (exp_addr_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL unexpected_issue: got addr %h expected no issue at %0t",
                   bus.ipsum_glb_read_addr_o, $time);
        end else begin
          e = exp_addr_q.pop_front();
          check("issue_addr", bus.ipsum_glb_read_addr_o, e);
        end
      end
    end
    for (int i = RD_LAT - 1; i > 0; i--) begin
      hv[i] = hv[i-1];
      ha[i] = ha[i-1];
    end
    hv[0] = !rst && bus.ipsum_glb_read_req_o && bus.ipsum_permit_push_i;
    ha[0] = bus.ipsum_glb_read_addr_o;
    bus.ipsum_glb_rdata_i = hv[RD_LAT-1] ? glb_word(ha[RD_LAT-1]) : 32'hDEAD_BEEF;
  end

  initial begin
    int start;
    for (int i = 0; i < RD_LAT; i++) begin
      hv[i] = 1'b0;
      ha[i] = '0;
    end
    rst = 1'b1;
    bus.ipsum_fifo_reset_i  = 1'b0;
    bus.ipsum_need_push_i   = 1'b0;
    bus.ipsum_need_pop_i    = 1'b0;
    bus.ipsum_permit_push_i = 1'b0;
    bus.ipsum_fifo_empty_i  = 1'b1;
    bus.ipsum_fifo_full_i   = 1'b0;
    set_base(32'h100, 4'b0011);
    repeat (2) next();
    rst = 1'b0;

    // reset state; pop gated by empty
    bus.ipsum_need_pop_i = 1'b1;
    sample();
    check_bit("rst_read_req", bus.ipsum_glb_read_req_o, 1'b0);
    check_bit("rst_push_en", bus.ipsum_fifo_push_en_o, 1'b0);
    check("rst_push_data", bus.ipsum_fifo_push_data_o, 32'h0);
    check_bit("rst_overflow", bus.ipsum_overflow_o, 1'b0);
    check("rst_read_addr", bus.ipsum_glb_read_addr_o, 32'h100);
    check_bit("pop_when_empty", bus.ipsum_fifo_pop_en_o, 1'b0);
    next();
    bus.ipsum_need_pop_i = 1'b0;

    // basic fetch
    bus.ipsum_permit_push_i = 1'b1;
    bus.ipsum_need_push_i   = 1'b1;
    expect_fetch();
    sample();
    check_bit("basic_req_not_yet", bus.ipsum_glb_read_req_o, 1'b0);
    next();
    bus.ipsum_need_push_i = 1'b0;
    sample();
    check_bit("basic_req", bus.ipsum_glb_read_req_o, 1'b1);
    check("basic_addr", bus.ipsum_glb_read_addr_o, 32'h100);
    next();
    sample();
    check("basic_next_addr", bus.ipsum_glb_read_addr_o, 32'h101);
    check_bit("basic_req_done", bus.ipsum_glb_read_req_o, 1'b0);
    repeat (3) next();
    do_flush();

    // credit limit
    set_base(32'h200, 4'b1111);
    bus.ipsum_permit_push_i = 1'b1;
    start = issues;
    for (int i = 0; i < 10; i++) begin
      bus.ipsum_need_push_i = 1'b1;
      if (i < 8) expect_fetch();
      next();
    end
    bus.ipsum_need_push_i = 1'b0;
    repeat (3) next();
    check("credit_cap_issues", 32'(issues - start), 32'd8);
    sample();
    check_bit("credit_cap_req_low", bus.ipsum_glb_read_req_o, 1'b0);
    next();
    bus.ipsum_need_pop_i   = 1'b1;
    bus.ipsum_fifo_empty_i = 1'b0;
    expect_fetch();
    sample();
    check_bit("pop_en", bus.ipsum_fifo_pop_en_o, 1'b1);
    next();
    bus.ipsum_need_pop_i   = 1'b0;
    bus.ipsum_fifo_empty_i = 1'b1;
    sample();
    check_bit("credit_returned_req", bus.ipsum_glb_read_req_o, 1'b1);
    next();
    check("credit_ninth_issue", 32'(issues - start), 32'd9);
    sample();
    check_bit("credit_exhausted_again", bus.ipsum_glb_read_req_o, 1'b0);
    repeat (3) next();
    do_flush();

    // grant stall
    set_base(32'h300, 4'b1100);
    bus.ipsum_permit_push_i = 1'b0;
    bus.ipsum_need_push_i   = 1'b1;
    expect_fetch();
    next();
    expect_fetch();
    next();
    bus.ipsum_need_push_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      sample();
      check_bit("stall_req_held", bus.ipsum_glb_read_req_o, 1'b1);
      check("stall_addr_held", bus.ipsum_glb_read_addr_o, 32'h300);
      next();
    end
    start = issues;
    bus.ipsum_permit_push_i = 1'b1;
    next();
    next();
    bus.ipsum_permit_push_i = 1'b0;
    check("stall_two_issues", 32'(issues - start), 32'd2);
    sample();
    check_bit("stall_req_done", bus.ipsum_glb_read_req_o, 1'b0);
    repeat (3) next();
    do_flush();

    // flush with a read in flight
    set_base(32'h400, 4'b1111);
    bus.ipsum_permit_push_i = 1'b1;
    bus.ipsum_need_push_i   = 1'b1;
    exp_addr_q.push_back(32'h400);
    next();
    bus.ipsum_need_push_i = 1'b0;
    sample();
    check_bit("flush_issue_req", bus.ipsum_glb_read_req_o, 1'b1);
    next();
    do_flush();
    for (int i = 0; i < 4; i++) begin
      sample();
      check_bit("flush_no_push", bus.ipsum_fifo_push_en_o, 1'b0);
      next();
    end
    check("flush_ptr_cleared", bus.ipsum_glb_read_addr_o, 32'h400);
    check_bit("flush_req_cleared", bus.ipsum_glb_read_req_o, 1'b0);

    // need_push coinciding with issue
    set_base(32'h500, 4'b1111);
    bus.ipsum_permit_push_i = 1'b1;
    bus.ipsum_need_push_i   = 1'b1;
    expect_fetch();
    next();
    expect_fetch();
    sample();
    check_bit("simul_req_first", bus.ipsum_glb_read_req_o, 1'b1);
    next();
    bus.ipsum_need_push_i = 1'b0;
    sample();
    check_bit("simul_req_cnt_held", bus.ipsum_glb_read_req_o, 1'b1);
    next();
    sample();
    check_bit("simul_req_drained", bus.ipsum_glb_read_req_o, 1'b0);
    next();

    // pop coinciding with issue at credit 1 (credit is 6 here)
    bus.ipsum_permit_push_i = 1'b0;
    for (int i = 0; i < 7; i++) begin
      bus.ipsum_need_push_i = 1'b1;
      expect_fetch();
      next();
    end
    bus.ipsum_need_push_i   = 1'b0;
    bus.ipsum_permit_push_i = 1'b1;
    repeat (5) next();
    bus.ipsum_need_pop_i   = 1'b1;
    bus.ipsum_fifo_empty_i = 1'b0;
    sample();
    check_bit("credit1_req", bus.ipsum_glb_read_req_o, 1'b1);
    check_bit("credit1_pop", bus.ipsum_fifo_pop_en_o, 1'b1);
    next();
    bus.ipsum_need_pop_i   = 1'b0;
    bus.ipsum_fifo_empty_i = 1'b1;
    sample();
    check_bit("credit1_held", bus.ipsum_glb_read_req_o, 1'b1);
    next();
    sample();
    check_bit("credit1_spent", bus.ipsum_glb_read_req_o, 1'b0);
    repeat (3) next();
    do_flush();

    // overflow
    set_base(32'h600, 4'b1111);
    bus.ipsum_permit_push_i = 1'b1;
    bus.ipsum_need_push_i   = 1'b1;
    expect_fetch();
    next();
    bus.ipsum_need_push_i = 1'b0;
    next();
    next();
    bus.ipsum_fifo_full_i = 1'b1;
    sample();
    check_bit("ovf_push_driven", bus.ipsum_fifo_push_en_o, 1'b1);
    check_bit("ovf_not_yet", bus.ipsum_overflow_o, 1'b0);
    next();
    bus.ipsum_fifo_full_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      sample();
      check_bit("ovf_sticky", bus.ipsum_overflow_o, 1'b1);
      next();
    end
    bus.ipsum_fifo_reset_i = 1'b1;
    sample();
    check_bit("ovf_before_clear", bus.ipsum_overflow_o, 1'b1);
    next();
    bus.ipsum_fifo_reset_i = 1'b0;
    sample();
    check_bit("ovf_cleared", bus.ipsum_overflow_o, 1'b0);
    next();

    repeat (3) next();
    check("leftover_pushes", 32'(exp_data_q.size()), 32'd0);
    check("leftover_issues", 32'(exp_addr_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
